// File: rtl/gmii_tx_framer_pkg.sv
// Shared state encoding, framing constants and bit-order helper for the GMII TX framer.
package gmii_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned MIN_PAYLOAD   = 60;
  localparam int unsigned FCS_LEN       = 4;

  // Reverse bit order of a byte (GMII sends LSB first, the CRC core is MSB first).
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = b[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_crc.sv
// 8-bit parallel CRC-32 (poly 0x04C11DB7, MSB-first, preset to all ones).
module crc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_rst,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Advance the register by eight serial shifts, data bit 7 first.
  always_comb begin
    logic fb;
    lfsr_d = lfsr_q;
    for (int unsigned i = 0; i < 8; i++) begin
      fb     = lfsr_d[31] ^ data_in[7 - i];
      lfsr_d = {lfsr_d[30:0], 1'b0};
      if (fb) begin
        lfsr_d = lfsr_d ^ 32'h04C1_1DB7;
      end
    end
  end

  // Preset on either reset, update only on enabled bytes.
  always_ff @(posedge clk) begin
    if (!rst_n || crc_rst) begin
      lfsr_q <= '1;
    end else if (crc_en) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign crc_out = lfsr_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional zero pad, FCS, inter-frame gap.
module gmii_tx_framer
  import gmii_tx_framer_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter bit          PAD_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] FCS_LAST = 16'(FCS_LEN - 1);
  localparam logic [15:0] MIN_PAY  = 16'(MIN_PAYLOAD);
  // The IDLE cycle that samples s_valid is the final gap cycle on the wire,
  // so IFG itself lasts one cycle less (and is skipped for a 1-cycle gap).
  localparam logic [15:0] IFG_LAST  = 16'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);
  localparam state_e      GAP_STATE = (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        er_q, er_d;
  logic [15:0] cnt_inc;
  logic [7:0]  fcs_byte;

  logic        crc_en;
  logic        crc_rst;
  logic [7:0]  crc_din;
  logic [31:0] crc_out;

  crc u_crc (
    .clk     (clk),
    .rst_n   (1'b1),
    .crc_rst (crc_rst),
    .crc_en  (crc_en),
    .data_in (crc_din),
    .crc_out (crc_out)
  );

  // Saturating payload count and the FCS byte selected by the byte index.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    case (cyc_q[1:0])
      2'd0:    fcs_byte = ~bitrev8(crc_out[31:24]);
      2'd1:    fcs_byte = ~bitrev8(crc_out[23:16]);
      2'd2:    fcs_byte = ~bitrev8(crc_out[15:8]);
      default: fcs_byte = ~bitrev8(crc_out[7:0]);
    endcase
  end

  // Next-state and launched-byte logic; outputs are registered one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    txd_d   = '0;
    en_d    = 1'b0;
    er_d    = 1'b0;
    crc_en  = 1'b0;
    crc_din = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        cyc_d = '0;
        if (s_valid) state_d = ST_PRE;
      end
      ST_PRE: begin
        txd_d = PREAMBLE_BYTE;
        en_d  = 1'b1;
        if (cyc_q == PRE_LAST) begin
          cyc_d   = '0;
          state_d = ST_SFD;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      ST_SFD: begin
        txd_d   = SFD_BYTE;
        en_d    = 1'b1;
        cnt_d   = '0;
        cyc_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        en_d = 1'b1;
        if (s_valid) begin
          txd_d   = s_data;
          crc_en  = 1'b1;
          crc_din = bitrev8(s_data);
          cnt_d   = cnt_inc;
          if (s_last) begin
            state_d = (PAD_EN && (cnt_inc < MIN_PAY)) ? ST_PAD : ST_FCS;
          end
        end else begin
          er_d    = 1'b1;
          cyc_d   = '0;
          state_d = GAP_STATE;
        end
      end
      ST_PAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        cnt_d  = cnt_inc;
        if (cnt_inc >= MIN_PAY) state_d = ST_FCS;
      end
      ST_FCS: begin
        txd_d = fcs_byte;
        en_d  = 1'b1;
        if (cyc_q == FCS_LAST) begin
          cyc_d   = '0;
          state_d = GAP_STATE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      ST_IFG: begin
        if (cyc_q == IFG_LAST) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered GMII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
    end
  end

  assign crc_rst    = rst || (state_q == ST_SFD);
  assign s_ready    = (state_q == ST_DATA) && !rst;
  assign busy       = (state_q != ST_IDLE) && !rst;
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: one instance without padding, one with.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;

  logic       rdy0, en0, er0, busy0;
  logic [7:0] txd0;
  logic       rdy1, en1, er1, busy1;
  logic [7:0] txd1;

  always #5 clk = ~clk;

  gmii_tx_framer #(.IFG_CYCLES(12), .PAD_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(rdy0), .gmii_txd(txd0), .gmii_tx_en(en0), .gmii_tx_er(er0), .busy(busy0));

  gmii_tx_framer #(.IFG_CYCLES(12), .PAD_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(rdy1), .gmii_txd(txd1), .gmii_tx_en(en1), .gmii_tx_er(er1), .busy(busy1));

  bit         sel = 1'b0;
  logic       rdy_s, en_s, er_s;
  logic [7:0] txd_s;
  assign rdy_s = sel ? rdy1 : rdy0;
  assign en_s  = sel ? en1  : en0;
  assign er_s  = sel ? er1  : er0;
  assign txd_s = sel ? txd1 : txd0;

  int errors = 0;
  int checks = 0;
  bit abort  = 1'b0;

  logic [7:0] cap_txd [0:8191];
  bit         cap_en  [0:8191];
  bit         cap_er  [0:8191];
  int         ncap = 0;

  logic [7:0] pay [0:255];
  logic [7:0] eb  [0:255];
  int         eb_n;

  typedef struct {
    string       name;
    bit          pad_dut;
    int          len;
    int          pattern;
    int          exp_len;
    logic [31:0] exp_fcs;
  } vec_t;

  vec_t vecs [6];

  always @(negedge clk) begin
    if (ncap < 8192) begin
      cap_txd[ncap] = txd_s;
      cap_en[ncap]  = en_s;
      cap_er[ncap]  = er_s;
      ncap++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_sw(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, eb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic fill_pay(input int pattern, input int n);
    for (int i = 0; i < n; i++) begin
      case (pattern)
        0:       pay[i] = 8'h31 + 8'(i);
        1:       pay[i] = 8'hAA;
        default: pay[i] = 8'(i * 7 + 3);
      endcase
    end
  endtask

  task automatic build_exp(input int n, input bit pad);
    eb_n = n;
    for (int i = 0; i < n; i++) eb[i] = pay[i];
    if (pad && n < 60) begin
      for (int i = n; i < 60; i++) eb[i] = 8'h00;
      eb_n = 60;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_u0", {txd0, en0, er0, rdy0, busy0}, '0);
    chk("reset_u1", {txd1, en1, er1, rdy1, busy1}, '0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int n, input bit drop, input bit with_last);
    bit stop;
    bit r;
    int t;
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) begin
      s_data  = pay[i];
      s_valid = 1'b1;
      s_last  = with_last && (i == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        r = rdy_s;
        @(posedge clk);
        #1;
        if (abort) begin stop = 1'b1; break; end
        if (r) break;
        t++;
        if (t > 200) begin
          chk("send_timeout", 64'(t), 0);
          stop = 1'b1;
          break;
        end
      end
    end
    if (drop || stop) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic find_run(input int from, output int s, output int len);
    s   = -1;
    len = 0;
    for (int i = from; i < ncap; i++) begin
      if (cap_en[i]) begin s = i; break; end
    end
    if (s >= 0) begin
      while (s + len < ncap && cap_en[s + len]) len++;
    end
  endtask

  task automatic check_frame(input string tag, input int s, input int len,
                             input int exp_len, input logic [31:0] exp_fcs);
    int          bad;
    logic [31:0] fcs;
    int          f;
    if (s < 0) begin
      chk({tag, "_found"}, 0, 1);
      return;
    end
    chk({tag, "_len"}, 64'(len), 64'(exp_len));
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (cap_txd[s + i] !== ((i < 7) ? 8'h55 : 8'hD5)) bad++;
    end
    chk({tag, "_preamble_bad"}, 64'(bad), 0);
    bad = 0;
    for (int i = 0; i < eb_n; i++) begin
      if (cap_txd[s + 8 + i] !== eb[i]) bad++;
    end
    chk({tag, "_payload_bad"}, 64'(bad), 0);
    f   = s + 8 + eb_n;
    fcs = {cap_txd[f + 3], cap_txd[f + 2], cap_txd[f + 1], cap_txd[f]};
    chk({tag, "_fcs"}, fcs, (exp_fcs != 0) ? exp_fcs : crc_sw(eb_n));
    bad = 0;
    for (int i = s; i < s + len; i++) if (cap_er[i]) bad++;
    chk({tag, "_tx_er"}, 64'(bad), 0);
  endtask

  initial begin
    int base, s, len, s2, len2, k, t, quiet;

    vecs[0] = '{"ascii9_nopad", 1'b0, 9,  0, 21, 32'hCBF4_3926};
    vecs[1] = '{"aa1_pad",      1'b1, 1,  1, 72, 32'h0};
    vecs[2] = '{"len60_pad",    1'b1, 60, 2, 72, 32'h0};
    vecs[3] = '{"len59_pad",    1'b1, 59, 2, 72, 32'h0};
    vecs[4] = '{"aa1_nopad",    1'b0, 1,  1, 13, 32'h0};
    vecs[5] = '{"len64_pad",    1'b1, 64, 2, 76, 32'h0};

    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].pad_dut;
      do_reset();
      fill_pay(vecs[v].pattern, vecs[v].len);
      build_exp(vecs[v].len, vecs[v].pad_dut);
      base = ncap;
      send(vecs[v].len, 1'b1, 1'b1);
      repeat (100) @(negedge clk);
      find_run(base, s, len);
      check_frame(vecs[v].name, s, len, vecs[v].exp_len, vecs[v].exp_fcs);
      if (v == 0 && s >= 0) begin
        quiet = 0;
        for (int i = s + len; i < s + len + 12; i++) if (cap_en[i]) quiet++;
        chk("ascii9_ifg_en", 64'(quiet), 0);
      end
    end

    // Underrun after the third payload byte.
    sel = 1'b1;
    do_reset();
    fill_pay(2, 3);
    base = ncap;
    send(3, 1'b1, 1'b0);
    repeat (60) @(negedge clk);
    find_run(base, s, len);
    chk("underrun_len", 64'(len), 12);
    if (s >= 0) begin
      chk("underrun_last", {cap_en[s + 11], cap_er[s + 11], cap_txd[s + 11]}, {1'b1, 1'b1, 8'h00});
      k = 0;
      for (int i = base; i < ncap; i++) if (cap_er[i]) k++;
      chk("underrun_er_count", 64'(k), 1);
      find_run(s + len, s2, len2);
      chk("underrun_no_fcs", 64'(s2), 64'(-1));
    end

    // Back-to-back 64-byte frames with s_valid held high.
    sel = 1'b0;
    do_reset();
    fill_pay(2, 64);
    build_exp(64, 1'b0);
    base = ncap;
    send(64, 1'b0, 1'b1);
    send(64, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    find_run(base, s, len);
    check_frame("b2b_first", s, len, 76, 32'h0);
    find_run(s + len, s2, len2);
    chk("b2b_gap", 64'(s2 - (s + len)), 12);
    check_frame("b2b_second", s2, len2, 76, 32'h0);

    // Reset pulse on the 20th tx_en cycle, then a clean frame.
    sel = 1'b1;
    do_reset();
    fill_pay(2, 64);
    abort = 1'b0;
    fork
      send(64, 1'b1, 1'b1);
      begin
        k = 0;
        t = 0;
        while (k < 20 && t < 400) begin
          @(negedge clk);
          t++;
          if (en_s) k++;
        end
        chk("rst_reach_20", 64'(k), 20);
        rst   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("rst_txen_drop", {en_s, er_s, busy1, rdy1}, '0);
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_idle_after", {en_s, busy1}, '0);
    fill_pay(0, 9);
    build_exp(9, 1'b1);
    base = ncap;
    send(9, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    find_run(base, s, len);
    check_frame("post_rst", s, len, 72, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
